// File: rtl/scazator_16bit_seq.sv
// scazator_16bit_seq: multi-cycle subtractor, one CLA group slice per clock with registered carry
module cla_group #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] g, p;
  logic [W:0]   c;
  assign g = x & y;
  assign p = x ^ y;
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign s  = p ^ c[W-1:0];
  assign co = c[W];
endmodule

module scazator_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / GROUP;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                     state, state_nx;
  logic [IW-1:0]              idx;
  logic [N-1:0][GROUP-1:0]    a_r, nb_r, diff_r;
  logic                       carry, cout, last;
  logic [GROUP-1:0]           sum;
  cla_group #(.W(GROUP)) u_cla (.x(a_r[idx]), .y(nb_r[idx]), .ci(carry), .s(sum), .co(cout));
  assign last      = idx == IW'(N - 1);
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign diff      = diff_r;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      nb_r   <= '0;
      carry  <= 1'b0;
      diff_r <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_r   <= a;
        nb_r  <= ~b;
        carry <= ~bin;
        idx   <= '0;
      end
      if (state == CALC) begin
        diff_r[idx] <= sum;
        carry       <= cout;
        idx         <= last ? '0 : idx + IW'(1);
        if (last) begin
          bout <= ~cout;
          ovf  <= (a_r[N-1][GROUP-1] == nb_r[N-1][GROUP-1]) && (sum[GROUP-1] != a_r[N-1][GROUP-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_scazator_16bit_seq.sv
// tb_scazator_16bit_seq: directed checks of the sequential subtractor
module tb_scazator_16bit_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  int          total = 0;
  int          bad = 0;

  scazator_16bit_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
    chk({tag, "_rdy"}, in_ready, 1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("%s_ov%0d", tag, i), out_valid, (i == 4) ? 1 : 0);
    end
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_irdy_done"}, in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_irdy_back"}, in_ready, 1);
    chk({tag, "_hold"}, diff, ed);
  endtask

  initial begin
    int n_res, last_c, overlap;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_irdy", in_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run("basic", 16'h3333, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0);
    run("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run("mixed", 16'hBE01, 16'h1234, 1'b1, 16'hABCC, 1'b0, 1'b0);

    // back-pressure with a stray operand pulse while DONE
    a = 16'h5555; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_ov0", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      a = 16'h0001; b = 16'h0002; bin = 1'b1; in_valid = (i == 1);
      tick();
      chk($sformatf("bp_ov_%0d", i), out_valid, 1);
      chk($sformatf("bp_diff_%0d", i), diff, 16'h4321);
      chk($sformatf("bp_bout_%0d", i), bout, 0);
      chk($sformatf("bp_ovf_%0d", i), ovf, 0);
      chk($sformatf("bp_irdy_%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_diff_after", diff, 16'h4321);
    tick();
    chk("bp_no_stray", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // asynchronous reset during the second CALC cycle
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_diff", diff, 0);
    chk("ar_bout", bout, 0);
    chk("ar_ovf", ovf, 0);
    chk("ar_ov", out_valid, 0);
    chk("ar_irdy", in_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ar_quiet_%0d", i), out_valid, 0);
    end
    run("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h0E0E, 1'b0, 1'b0);

    // continuous streaming
    a = 16'h3333; b = 16'h1111; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n_res = 0; last_c = 0; overlap = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (in_ready && out_valid) overlap++;
      if (out_valid) begin
        chk($sformatf("tp_diff_c%0d", c), diff, 16'h2222);
        chk($sformatf("tp_pos_c%0d", c), c - last_c, (n_res == 0) ? 5 : 6);
        last_c = c;
        n_res++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("tp_count", n_res, 4);
    chk("tp_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scazator_16bit_seq.md
Name: scazator_16bit_seq

Overview:
Multi-cycle 16-bit subtractor computing diff = a - b - bin. It reuses the team's 4-bit carry-lookahead group, processing one GROUP-bit slice per clock and rippling the carry through a register between slices. Operands enter and results leave through valid/ready handshakes. It pairs with the combinational 16-bit adder as the subtract direction of the datapath, for use where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP.
GROUP, 4, bits processed per cycle (one CLA group).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set present
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out (1 when a < b + bin as unsigned values)
ovf  output  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, slice index=0.
  - diff=0, bout=0, ovf=0, out_valid=0, in_ready=1.
  - Internal operand and carry registers cleared.
  - Reset mid-CALC or mid-DONE abandons the operation; no result is ever presented.
- Arithmetic:
  - Computed as a + ~b + carry, with initial carry = ~bin.
  - bout = ~(final carry).
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clk edge with in_valid=1, latch a, ~b and carry=~bin; set index=0; go to CALC.
- CALC:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each cycle, the CLA group adds slice [index*GROUP +: GROUP] with the registered carry.
  - The slice sum is written into diff at that slice, the carry register is updated, and index increments.
  - After the slice with index = WIDTH/GROUP-1, register bout and ovf and go to DONE.
- DONE:
  - out_valid=1; diff, bout and ovf stay stable.
  - When out_valid && out_ready at a clk edge, go to IDLE. The outputs hold their last values but out_valid drops.
- Latency:
  - Operands accepted at edge k; out_valid high after edge k+WIDTH/GROUP (k+4 at defaults).
  - Minimum spacing between accepted operations is WIDTH/GROUP+2 cycles: accept, 4×CALC, DONE, back to IDLE.
- Back-to-back operation: in_ready stays low in DONE, so a new operation cannot be accepted on the same edge that returns the block to IDLE.
- Partial diff bits may change during CALC. Consumers must sample only while out_valid=1.
- No combinational path from inputs to outputs. in_ready and out_valid decode from state only.

Test Plan:
- a=0x3333, b=0x1111, bin=0 -> diff=0x2222, bout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Also a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also a=0xBE01, b=0x1234, bin=1 -> diff=0xABCC, bout=0, ovf=0.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, diff/bout/ovf stable, in_ready=0. Pulse in_valid with other operands -> ignored, and the first result is delivered unchanged.
- Reset mid-operation: assert rst_n=0 during the 2nd CALC cycle -> all outputs 0 and in_ready=1 immediately (asynchronously). After release, a fresh a=0x0F0F, b=0x0101, bin=0 -> diff=0x0E0E, bout=0.
- Throughput: keep in_valid=1 with out_ready=1 continuously -> one result every 6 cycles. Check in_ready never overlaps out_valid.
